tx: RTL and testbench

TX -- requirements
Module: tx

---
 rtl/tx_defs.sv | 26 ++
 rtl/tx_blfgen.sv | 35 +++
 rtl/tx.sv | 127 ++++++++++++
 tb/tb_tx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/tx_defs.sv
// tx_defs: state encodings, framing constants and half-symbol length helper for the backscatter transmitter
package tx_defs;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PILOT,
        S_PREAMBLE,
        S_DATA,
        S_DUMMY,
        S_DONE
    } state_t;

    localparam int PILOT_HALVES = 24;
    localparam int PRE_HALVES   = 12;

    // Preamble half-symbol levels; bit i is emitted i-th: 1,1,0,1,0,0,1,0,0,0,1,1 (carries the FM0 violation)
    localparam logic [11:0] PRE_PAT = 12'hC4B;

    // Half-symbol length: TRcal/16 for DR 8, TRcal*3/128 for DR 64/3, kept to 6 bits and never below 1
    function automatic logic [5:0] calc_hp(input logic [9:0] trcal, input logic dr);
        logic [5:0] h;
        h = 6'(dr ? (12'(trcal) * 12'd3) >> 7 : 12'(trcal) >> 4);
        return (h == 6'd0) ? 6'd1 : h;
    endfunction

endpackage

// File: rtl/tx_blfgen.sv
// tx_blfgen: freezes the half-symbol length at reply start and times every half-symbol
module tx_blfgen
    import tx_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [9:0] trcal,
    input  logic       dr,
    input  logic       run,
    output logic       tick,
    output logic [5:0] hp
);

    logic [5:0] hp_q;
    logic [5:0] cnt_q, cnt_d;

    assign hp   = hp_q;
    assign tick = run && (cnt_q == hp_q - 6'd1);

    // Counter rests at 0 while stopped so the first half after a start is a full hp cycles long
    always_comb cnt_d = (!run || tick) ? 6'd0 : cnt_q + 6'd1;

    // Half length is captured once per reply; the counter wraps on every half-symbol boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hp_q  <= 6'd0;
            cnt_q <= 6'd0;
        end else begin
            if (load) hp_q <= calc_hp(trcal, dr);
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tx.sv
// tx: FM0 backscatter reply sequencer (pilot, preamble, payload, dummy-1) driving the modulator level
module tx
    import tx_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] trcal,
    input  logic       dr,
    input  logic       trext,
    input  logic       bitin,
    input  logic       lastbit,
    output logic       txout,
    output logic       bitack,
    output logic       busy,
    output logic       done
);

    state_t     state_q;
    logic [4:0] idx_q;
    logic       first_q;
    logic       bit_q;
    logic       last_q;
    logic       tick;
    logic       load;
    logic       run;
    logic [5:0] hp;

    assign load = (state_q == S_IDLE) && start;
    // Half timing starts only once the first level is on the line and a valid length is loaded
    assign run  = busy && !first_q && (hp != 6'd0);

    tx_blfgen u_blfgen (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .trcal (trcal),
        .dr    (dr),
        .run   (run),
        .tick  (tick),
        .hp    (hp)
    );

    // Reply sequencer; idx_q counts halves in PILOT/PREAMBLE and marks the mid-symbol in DATA/DUMMY
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
            first_q <= 1'b0;
            bit_q   <= 1'b0;
            last_q  <= 1'b0;
            txout   <= 1'b0;
            bitack  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            bitack <= 1'b0;
            done   <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    busy    <= 1'b1;
                    first_q <= 1'b1;
                    idx_q   <= 5'd0;
                    state_q <= trext ? S_PILOT : S_PREAMBLE;
                end
                S_PILOT: if (first_q) begin
                    txout   <= 1'b1;
                    first_q <= 1'b0;
                end else if (tick) begin
                    if (idx_q == 5'(PILOT_HALVES - 1)) begin
                        state_q <= S_PREAMBLE;
                        idx_q   <= 5'd0;
                        txout   <= PRE_PAT[0];
                    end else begin
                        idx_q <= idx_q + 5'd1;
                        txout <= ~txout;
                    end
                end
                S_PREAMBLE: if (first_q) begin
                    txout   <= PRE_PAT[0];
                    first_q <= 1'b0;
                end else if (tick) begin
                    if (idx_q == 5'(PRE_HALVES - 1)) begin
                        state_q <= S_DATA;
                        idx_q   <= 5'd0;
                        bit_q   <= bitin;
                        last_q  <= lastbit;
                        bitack  <= 1'b1;
                        txout   <= ~txout;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                        txout <= PRE_PAT[4'(idx_q + 5'd1)];
                    end
                end
                S_DATA: if (tick) begin
                    if (!idx_q[0]) begin
                        idx_q <= 5'd1;
                        txout <= bit_q ? txout : ~txout;
                    end else if (last_q) begin
                        state_q <= S_DUMMY;
                        idx_q   <= 5'd0;
                        txout   <= ~txout;
                    end else begin
                        idx_q  <= 5'd0;
                        bit_q  <= bitin;
                        last_q <= lastbit;
                        bitack <= 1'b1;
                        txout  <= ~txout;
                    end
                end
                S_DUMMY: if (tick) begin
                    if (!idx_q[0]) begin
                        idx_q <= 5'd1;
                    end else begin
                        state_q <= S_DONE;
                        idx_q   <= 5'd0;
                        done    <= 1'b1;
                        txout   <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx.sv
// tb_tx: table-driven and randomized replies checked cycle by cycle against a half-symbol level model
module tb_tx;

    logic       clk = 1'b0;
    logic       reset, start, dr, trext, bitin, lastbit;
    logic [9:0] trcal;
    logic       txout, bitack, busy, done;
    int         checks = 0;
    int         passes = 0;

    typedef struct {
        logic [9:0]  trcal;
        logic        dr;
        logic        trext;
        logic [31:0] bits;
        int          nbits;
        int          len;
    } vec_t;

    typedef struct packed {
        logic tx;
        logic ack;
        logic bsy;
        logic dn;
    } exp_t;

    exp_t m[$];
    vec_t vecs[6];

    tx dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .trcal   (trcal),
        .dr      (dr),
        .trext   (trext),
        .bitin   (bitin),
        .lastbit (lastbit),
        .txout   (txout),
        .bitack  (bitack),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int ref_hp(input int tc, input bit d);
        int h;
        h = d ? (tc * 3) / 128 : tc / 16;
        h = h % 64;
        return (h == 0) ? 1 : h;
    endfunction

    function automatic void put(input bit t, input bit a, input bit b, input bit d);
        exp_t e;
        e.tx = t; e.ack = a; e.bsy = b; e.dn = d;
        m.push_back(e);
    endfunction

    // Expected outputs per cycle, from the cycle after the accepting edge to one idle cycle past done
    function automatic void build(input int tc, input bit d, input bit te, input logic [31:0] bits, input int n);
        bit halves[$];
        bit sstart[$];
        int pre[12] = '{1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1};
        int h;
        bit lvl;
        bit b;
        h = ref_hp(tc, d);
        m.delete();
        if (te) for (int i = 0; i < 24; i++) begin halves.push_back(i % 2 == 0); sstart.push_back(1'b0); end
        for (int i = 0; i < 12; i++) begin halves.push_back(pre[i] != 0); sstart.push_back(1'b0); end
        lvl = halves[halves.size() - 1];
        for (int i = 0; i <= n; i++) begin
            b = (i == n) ? 1'b1 : bits[i];
            lvl = !lvl;
            halves.push_back(lvl); sstart.push_back(i < n);
            if (!b) lvl = !lvl;
            halves.push_back(lvl); sstart.push_back(1'b0);
        end
        put(0, 0, 1, 0);
        foreach (halves[i]) for (int c = 0; c < h; c++) put(halves[i], sstart[i] && c == 0, 1, 0);
        put(0, 0, 0, 1);
        put(0, 0, 0, 0);
    endfunction

    task automatic run(input string tag, input logic [9:0] tc, input bit d, input bit te,
                       input logic [31:0] bits, input int n, input int exp_len, input int inject);
        int werr = 0, aerr = 0, berr = 0, derr = 0, acks = 0, bi = 0, kdone = -1;
        build(tc, d, te, bits, n);
        @(negedge clk);
        trcal = tc; dr = d; trext = te; bitin = bits[0]; lastbit = (n == 1); start = 1'b1;
        @(negedge clk);
        start = 1'b0; trcal = 10'($urandom); dr = 1'($urandom); trext = 1'($urandom);
        for (int k = 0; k < m.size(); k++) begin
            if (k > 0) @(negedge clk);
            if (txout !== m[k].tx) werr++;
            if (bitack !== m[k].ack) aerr++;
            if (busy !== m[k].bsy) berr++;
            if (done !== m[k].dn) derr++;
            if (done === 1'b1 && kdone < 0) kdone = k;
            if (bitack === 1'b1) begin
                acks++;
                bi++;
                if (bi < n) begin bitin = bits[bi]; lastbit = (bi == n - 1); end
            end
            start = (k == inject);
        end
        start = 1'b0;
        check({tag, " txout"}, werr, 0);
        check({tag, " bitack"}, aerr, 0);
        check({tag, " busy"}, berr, 0);
        check({tag, " done"}, derr, 0);
        check({tag, " acks"}, acks, n);
        check({tag, " len"}, kdone - 1, (exp_len < 0) ? m.size() - 3 : exp_len);
    endtask

    initial begin
        int e;
        vecs = '{
            '{10'd160,  1'b0, 1'b0, 32'h1,  2, 180},
            '{10'd640,  1'b1, 1'b1, 32'h1,  2, 630},
            '{10'd8,    1'b0, 1'b0, 32'h5,  3, 20},
            '{10'd1023, 1'b0, 1'b0, 32'h1,  1, 1008},
            '{10'd42,   1'b1, 1'b1, 32'h0,  1, 40},
            '{10'd100,  1'b1, 1'b0, 32'hA5, 8, 60}
        };
        reset = 1'b1; start = 1'b0; trcal = 10'd0; dr = 1'b0; trext = 1'b0; bitin = 1'b0; lastbit = 1'b0;
        repeat (3) @(negedge clk);
        check("reset txout", int'(txout), 0);
        check("reset bitack", int'(bitack), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            run($sformatf("vec%0d", i), vecs[i].trcal, vecs[i].dr, vecs[i].trext,
                vecs[i].bits, vecs[i].nbits, vecs[i].len, -1);

        run("start mid-data", 10'd160, 1'b0, 1'b0, 32'h1, 2, 180, 140);

        @(negedge clk);
        trcal = 10'd160; dr = 1'b0; trext = 1'b0; bitin = 1'b1; lastbit = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort txout", int'(txout), 0);
        check("abort busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        e = 0;
        repeat (20) begin
            @(negedge clk);
            if (txout !== 1'b0 || busy !== 1'b0 || bitack !== 1'b0 || done !== 1'b0) e++;
        end
        check("post-reset quiet", e, 0);
        run("after reset", 10'd160, 1'b0, 1'b0, 32'h1, 2, 180, -1);

        for (int r = 0; r < 4; r++)
            run($sformatf("rand%0d", r), 10'($urandom_range(16, 400)), 1'($urandom), 1'($urandom),
                $urandom, 32, -1, -1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
